// File: rtl/data_memory_sized.sv
// Byte-addressed MEM-stage data memory: sub-word loads/stores, registered reads,
// alignment fault pulses and a post-reset clear sequencer.
module data_memory_sized #(
  parameter int ADDR_W         = 14,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       write_data,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              misaligned,
  output logic              busy
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state;
  logic [IDX_W-1:0] clr_idx;
  logic [3:0][7:0]  mem [DEPTH];

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic             fault;
  logic             req;
  logic             do_store;
  logic             do_load;

  assign word_idx = addr[ADDR_W-1:2];
  assign lane     = addr[1:0];

  assign fault    = ((size == SIZE_H) && addr[0]) ||
                    ((size == SIZE_W) && (lane != 2'b00)) ||
                    (size == 2'b11);
  assign req      = (state == READY) && (mem_read || mem_write);
  assign do_store = req && mem_write && !fault;
  assign do_load  = req && mem_read && !fault;

  // Store data is replicated across lanes; the byte enables pick the target lanes.
  logic [3:0]       store_be;
  logic [3:0][7:0]  store_lanes;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    store_be    = 4'b0000;
    store_lanes = write_data;
    unique case (size)
      SIZE_B: begin
        store_be          = 4'b0001 << lane;
        store_lanes       = {4{write_data[7:0]}};
      end
      SIZE_H: begin
        store_be          = addr[1] ? 4'b1100 : 4'b0011;
        store_lanes       = {2{write_data[15:0]}};
      end
      SIZE_W: store_be    = 4'b1111;
      default: store_be   = 4'b0000;
    endcase
  end

  // Single write port shared by the clear sequencer and normal stores.
  logic [IDX_W-1:0] we_idx;
  logic [3:0]       we_be;
  logic [3:0][7:0]  we_data;

  always_comb begin
    if (state == CLEAR) begin
      we_idx  = clr_idx;
      we_be   = 4'b1111;
      we_data = '0;
    end else begin
      we_idx  = word_idx;
      we_be   = do_store ? store_be : 4'b0000;
      we_data = store_lanes;
    end
    if (rst) we_be = 4'b0000;
  end

  // NOTE: the array has no reset branch; zeroing is the sequencer's job, which keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_be[b]) mem[we_idx][b] <= we_data[b];
    end
  end

  logic [3:0][7:0] rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [31:0]     load_ext;

  always_comb begin
    rd_word = mem[word_idx];
    rd_byte = rd_word[lane];
    rd_half = addr[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};
    unique case (size)
      SIZE_B:  load_ext = load_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SIZE_H:  load_ext = load_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_ext = rd_word;
    endcase
  end

  // NOTE: non-blocking updates mean a load sharing an edge with a store sees the pre-store word.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      misaligned <= 1'b0;
      clr_idx    <= '0;
      state      <= CLEAR_ON_RESET ? CLEAR : READY;
      busy       <= CLEAR_ON_RESET;
    end else begin
      read_valid <= do_load;
      misaligned <= req && fault;
      if (do_load) read_data <= load_ext;
      if (state == CLEAR) begin
        clr_idx <= clr_idx + IDX_W'(1);
        if (clr_idx == IDX_W'(DEPTH - 1)) begin
          state <= READY;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Self-checking bench for data_memory_sized (ADDR_W=6, 16 words): vector table
// with a scoreboard queue, plus hand-written clear/restart sequences.
module tb_data_memory_sized;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] SX = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  addr;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] read_data;
  logic        read_valid;
  logic        misaligned;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [1:0]  size;
    logic        uns;
    logic        exp_valid;
    logic        exp_mis;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        valid;
    logic        mis;
    logic [31:0] data;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  data_memory_sized #(.ADDR_W(6), .CLEAR_ON_RESET(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .write_data    (write_data),
    .mem_write     (mem_write),
    .mem_read      (mem_read),
    .size          (size),
    .load_unsigned (load_unsigned),
    .read_data     (read_data),
    .read_valid    (read_valid),
    .misaligned    (misaligned),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] a, input logic [31:0] wd, input logic we,
                       input logic re, input logic [1:0] sz, input logic uns);
    addr          = a;
    write_data    = wd;
    mem_write     = we;
    mem_read      = re;
    size          = sz;
    load_unsigned = uns;
  endtask

  task automatic idle();
    drive(6'h00, 32'h0, 1'b0, 1'b0, SW, 1'b0);
  endtask

  function automatic vec_t mk(input logic [5:0] a, input logic [31:0] wd, input logic we,
                              input logic re, input logic [1:0] sz, input logic uns,
                              input logic ev, input logic em, input logic [31:0] ed);
    vec_t v;
    v.addr = a; v.wdata = wd; v.we = we; v.re = re; v.size = sz; v.uns = uns;
    v.exp_valid = ev; v.exp_mis = em; v.exp_data = ed;
    return v;
  endfunction

  // Drive one request at a negedge, let the DUT clock it, compare at the next negedge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    drive(v.addr, v.wdata, v.we, v.re, v.size, v.uns);
    sb.push_back('{v.exp_valid, v.exp_mis, v.exp_data});
    @(posedge clk);
    @(negedge clk);
    idle();
    e = sb.pop_front();
    check({tag, " read_valid"}, read_valid, e.valid);
    check({tag, " misaligned"}, misaligned, e.mis);
    check({tag, " read_data"}, read_data, e.data);
  endtask

  task automatic do_reset(input string tag);
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check({tag, " rst read_data"}, read_data, 32'h0);
    check({tag, " rst read_valid"}, read_valid, 1'b0);
    check({tag, " rst misaligned"}, misaligned, 1'b0);
    check({tag, " rst busy"}, busy, 1'b1);
  endtask

  // Counts busy cycles starting at the sample right after a reset edge; optionally
  // re-asserts rst once at busy cycle restart_at and pokes requests while busy.
  task automatic clear_phase(input int restart_at, input bit poke, output int busy_len);
    bit restarted = 1'b0;
    busy_len = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (busy !== 1'b1) break;
      busy_len++;
      check($sformatf("busy%0d read_valid", cyc), read_valid, 1'b0);
      check($sformatf("busy%0d misaligned", cyc), misaligned, 1'b0);
      if (poke) begin
        case (cyc % 3)
          0:       drive(6'h00, 32'hFFFF_FFFF, 1'b1, 1'b0, SW, 1'b0);
          1:       drive(6'h00, 32'h0, 1'b0, 1'b1, SW, 1'b0);
          default: drive(6'h01, 32'h0, 1'b0, 1'b1, SX, 1'b0);
        endcase
      end
      if (!restarted && busy_len == restart_at) begin
        rst       = 1'b1;
        restarted = 1'b1;
        busy_len  = 0;
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
    end
    check("post-clear read_valid", read_valid, 1'b0);
    check("post-clear misaligned", misaligned, 1'b0);
    idle();
  endtask

  initial begin
    int len;
    logic [31:0] held;

    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);

    do_reset("por");
    clear_phase(0, 1'b0, len);
    check("por clear length", len, 16);

    tbl.push_back(mk(6'h3C, 32'h0,         1'b0, 1'b1, SW, 1'b0, 1'b1, 1'b0, 32'h0000_0000));
    tbl.push_back(mk(6'h10, 32'h8899_AABB, 1'b1, 1'b0, SW, 1'b0, 1'b0, 1'b0, 32'h0000_0000));
    tbl.push_back(mk(6'h10, 32'h0,         1'b0, 1'b1, SB, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFBB));
    tbl.push_back(mk(6'h11, 32'h0,         1'b0, 1'b1, SB, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFAA));
    tbl.push_back(mk(6'h12, 32'h0,         1'b0, 1'b1, SB, 1'b0, 1'b1, 1'b0, 32'hFFFF_FF99));
    tbl.push_back(mk(6'h13, 32'h0,         1'b0, 1'b1, SB, 1'b0, 1'b1, 1'b0, 32'hFFFF_FF88));
    tbl.push_back(mk(6'h10, 32'h0,         1'b0, 1'b1, SB, 1'b1, 1'b1, 1'b0, 32'h0000_00BB));
    tbl.push_back(mk(6'h11, 32'h0,         1'b0, 1'b1, SB, 1'b1, 1'b1, 1'b0, 32'h0000_00AA));
    tbl.push_back(mk(6'h12, 32'h0,         1'b0, 1'b1, SB, 1'b1, 1'b1, 1'b0, 32'h0000_0099));
    tbl.push_back(mk(6'h13, 32'h0,         1'b0, 1'b1, SB, 1'b1, 1'b1, 1'b0, 32'h0000_0088));
    tbl.push_back(mk(6'h11, 32'hFFFF_FF5A, 1'b1, 1'b0, SB, 1'b0, 1'b0, 1'b0, 32'h0000_0088));
    tbl.push_back(mk(6'h12, 32'hABCD_1234, 1'b1, 1'b0, SH, 1'b0, 1'b0, 1'b0, 32'h0000_0088));
    tbl.push_back(mk(6'h10, 32'h0,         1'b0, 1'b1, SW, 1'b0, 1'b1, 1'b0, 32'h1234_5ABB));
    tbl.push_back(mk(6'h12, 32'h0,         1'b0, 1'b1, SH, 1'b0, 1'b1, 1'b0, 32'h0000_1234));
    tbl.push_back(mk(6'h10, 32'h0,         1'b0, 1'b1, SH, 1'b1, 1'b1, 1'b0, 32'h0000_5ABB));
    tbl.push_back(mk(6'h04, 32'h1122_3344, 1'b1, 1'b0, SW, 1'b0, 1'b0, 1'b0, 32'h0000_5ABB));
    tbl.push_back(mk(6'h11, 32'h0,         1'b0, 1'b1, SH, 1'b0, 1'b0, 1'b1, 32'h0000_5ABB));
    tbl.push_back(mk(6'h06, 32'hDEAD_BEEF, 1'b1, 1'b0, SW, 1'b0, 1'b0, 1'b1, 32'h0000_5ABB));
    tbl.push_back(mk(6'h00, 32'h0,         1'b0, 1'b1, SX, 1'b0, 1'b0, 1'b1, 32'h0000_5ABB));
    tbl.push_back(mk(6'h04, 32'h0,         1'b0, 1'b1, SW, 1'b0, 1'b1, 1'b0, 32'h1122_3344));
    tbl.push_back(mk(6'h08, 32'h0000_8001, 1'b1, 1'b0, SH, 1'b0, 1'b0, 1'b0, 32'h1122_3344));
    tbl.push_back(mk(6'h08, 32'h0,         1'b0, 1'b1, SH, 1'b0, 1'b1, 1'b0, 32'hFFFF_8001));
    tbl.push_back(mk(6'h08, 32'h0,         1'b0, 1'b1, SH, 1'b1, 1'b1, 1'b0, 32'h0000_8001));
    tbl.push_back(mk(6'h08, 32'h0,         1'b0, 1'b1, SW, 1'b1, 1'b1, 1'b0, 32'h0000_8001));
    tbl.push_back(mk(6'h0A, 32'h0,         1'b0, 1'b1, SH, 1'b0, 1'b1, 1'b0, 32'h0000_0000));
    tbl.push_back(mk(6'h00, 32'h0,         1'b0, 1'b0, SW, 1'b0, 1'b0, 1'b0, 32'h0000_0000));
    tbl.push_back(mk(6'h20, 32'h0000_0007, 1'b1, 1'b0, SW, 1'b0, 1'b0, 1'b0, 32'h0000_0000));
    tbl.push_back(mk(6'h20, 32'hCAFE_F00D, 1'b1, 1'b1, SW, 1'b0, 1'b1, 1'b0, 32'h0000_0007));
    tbl.push_back(mk(6'h20, 32'h0,         1'b0, 1'b1, SW, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D));
    tbl.push_back(mk(6'h24, 32'h1234_5678, 1'b1, 1'b0, SX, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D));
    tbl.push_back(mk(6'h24, 32'h0,         1'b0, 1'b1, SW, 1'b0, 1'b1, 1'b0, 32'h0000_0000));
    tbl.push_back(mk(6'h07, 32'h0,         1'b0, 1'b1, SB, 1'b1, 1'b1, 1'b0, 32'h0000_0011));
    tbl.push_back(mk(6'h02, 32'h0,         1'b0, 1'b1, SW, 1'b0, 1'b0, 1'b1, 32'h0000_0011));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Fill every word with a non-zero pattern so the second clear has something to erase.
    held = 32'h0000_0011;
    for (int i = 0; i < 16; i++)
      apply(mk(6'(i * 4), 32'hA5A5_0000 | 32'(i), 1'b1, 1'b0, SW, 1'b0, 1'b0, 1'b0, held),
            $sformatf("fill%0d", i));
    apply(mk(6'h3C, 32'h0, 1'b0, 1'b1, SW, 1'b0, 1'b1, 1'b0, 32'hA5A5_000F), "fill readback");

    do_reset("mid");
    clear_phase(5, 1'b1, len);
    check("restarted clear length", len, 16);

    for (int i = 0; i < 16; i++)
      apply(mk(6'(i * 4), 32'h0, 1'b0, 1'b1, SW, 1'b0, 1'b1, 1'b0, 32'h0),
            $sformatf("cleared%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
